// File: rtl/alu_sequencer.sv
// jacaranda-8 ALU: single-cycle logic/arith, iterative shifts, optional iterative multiply (ALU_MUL_EN).
// Latency: 1 for single-cycle/illegal ops, shamt+1 for SLL/SRL, WIDTH+1 for MUL.
// Backpressure: in_ready low outside IDLE; the result is held stable in DONE until out_ready.
module alu_sequencer #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    // One extra bit so the counter can hold WIDTH for the multiply.
    localparam int CNT_W = SHAMT_W + 1;

    logic [1:0]       state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [CNT_W-1:0] cnt_q;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] ex_b;
    logic [WIDTH-1:0] ex_acc;
`endif

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sc_result;
    logic               sc_carry;
    logic               sc_illegal;
    logic               sc_iter;

    logic [WIDTH-1:0]   ex_a;
    logic [WIDTH-1:0]   ex_res;
    logic [WIDTH-1:0]   ex_hi;
    logic               ex_carry;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign shamt     = operand_b[SHAMT_W-1:0];

    // Decode of the incoming request; sc_iter marks ops that need EXEC cycles.
    always_comb begin
        sc_result  = '0;
        sc_carry   = 1'b0;
        sc_illegal = 1'b0;
        sc_iter    = 1'b0;
        case (opcode)
            OP_ADD: {sc_carry, sc_result} = {1'b0, operand_a} + {1'b0, operand_b};
            OP_SUB: begin
                sc_result = operand_a - operand_b;
                sc_carry  = (operand_a < operand_b);
            end
            OP_AND: sc_result = operand_a & operand_b;
            OP_OR:  sc_result = operand_a | operand_b;
            OP_XOR: sc_result = operand_a ^ operand_b;
            OP_NOT: sc_result = ~operand_a;
            OP_SLL, OP_SRL: begin
                if (shamt == '0) sc_result = operand_a;
                else             sc_iter   = 1'b1;
            end
`ifdef ALU_MUL_EN
            OP_MUL: sc_iter = 1'b1;
`endif
            default: sc_illegal = 1'b1;
        endcase
    end

    // One iteration step: a single-bit shift, or one shift-add multiply step.
    always_comb begin
        ex_a     = a_q;
        ex_carry = 1'b0;
        ex_hi    = '0;
        case (op_q)
            OP_SLL: begin
                ex_a     = a_q << 1;
                ex_carry = a_q[WIDTH-1];
            end
            OP_SRL: begin
                ex_a     = a_q >> 1;
                ex_carry = a_q[0];
            end
            default: ex_a = a_q;
        endcase
        ex_res = ex_a;
`ifdef ALU_MUL_EN
        mul_sum = b_q[0] ? ({1'b0, acc_q} + {1'b0, a_q}) : {1'b0, acc_q};
        ex_acc  = mul_sum[WIDTH:1];
        ex_b    = {mul_sum[0], b_q[WIDTH-1:1]};
        if (op_q == OP_MUL) begin
            ex_res   = ex_b;
            ex_hi    = ex_acc;
            ex_carry = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            cnt_q      <= '0;
            result     <= '0;
            result_hi  <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            illegal    <= 1'b0;
`ifdef ALU_MUL_EN
            b_q        <= '0;
            acc_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= opcode;
                        a_q  <= operand_a;
`ifdef ALU_MUL_EN
                        b_q   <= operand_b;
                        acc_q <= '0;
`endif
                        if (sc_iter) begin
                            state_q <= S_EXEC;
                            cnt_q   <= (opcode == OP_MUL) ? CNT_W'(WIDTH) : {1'b0, shamt};
                        end else begin
                            state_q    <= S_DONE;
                            result     <= sc_result;
                            result_hi  <= '0;
                            flag_carry <= sc_carry;
                            flag_zero  <= !sc_illegal && (sc_result == '0);
                            illegal    <= sc_illegal;
                        end
                    end
                end
                S_EXEC: begin
                    a_q   <= ex_a;
                    cnt_q <= cnt_q - CNT_W'(1);
`ifdef ALU_MUL_EN
                    b_q   <= ex_b;
                    acc_q <= ex_acc;
`endif
                    if (cnt_q == CNT_W'(1)) begin
                        state_q    <= S_DONE;
                        result     <= ex_res;
                        result_hi  <= ex_hi;
                        flag_carry <= ex_carry;
                        flag_zero  <= (ex_res == '0) && (ex_hi == '0);
                        illegal    <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: hand-computed vectors per feature, latency and handshake checks.
// Expectations for opcode 1001 follow the ALU_MUL_EN build setting.
module tb_alu_sequencer;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [7:0] hi;
        logic       c;
        logic       z;
        logic       ill;
        logic [4:0] lat;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       flag_zero;
    logic       flag_carry;
    logic       illegal;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_sequencer #(.WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result_hi  (result_hi),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .illegal    (illegal)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    task automatic start_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clock);
        opcode    = op;
        operand_a = a;
        operand_b = b;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Latency 1 means out_valid is already high just after the accept edge.
    task automatic wait_result(output int l);
        l = 1;
        while (!out_valid && l < 40) begin
            @(posedge clock);
            #1;
            l++;
        end
    endtask

    task automatic release_result();
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = OP_ADD;
        operand_a = 8'h01;
        operand_b = 8'h01;
        repeat (2) @(posedge clock);
        #1;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        total_cnt++;
        if ({out_valid, in_ready, result, result_hi, flag_carry, flag_zero, illegal} !== {1'b0, 1'b1, 8'h00, 8'h00, 3'b000})
            $display("FAIL reset_state: got v=%b rdy=%b res=%h hi=%h c=%b z=%b ill=%b, want v=0 rdy=1 res=00 hi=00 c=0 z=0 ill=0",
                     out_valid, in_ready, result, result_hi, flag_carry, flag_zero, illegal);
        else pass_cnt++;
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b0;
        @(posedge clock);
        #1;
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL reset_release: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_arith_logic();
        vec_t tbl [10];
        int   l;
        tbl = '{
            '{OP_ADD, 8'hF0, 8'h20, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 5'd1},
            '{OP_ADD, 8'h12, 8'h34, 8'h46, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1},
            '{OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 5'd1},
            '{OP_SUB, 8'h05, 8'h05, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 5'd1},
            '{OP_SUB, 8'h03, 8'h05, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b0, 5'd1},
            '{OP_AND, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1},
            '{OP_OR,  8'hF0, 8'h3C, 8'hFC, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1},
            '{OP_XOR, 8'hF0, 8'h3C, 8'hCC, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1},
            '{OP_NOT, 8'hF0, 8'h3C, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1},
            '{OP_NOT, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 5'd1}
        };
        for (int i = 0; i < 10; i++) begin
            start_op(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_result(l);
            total_cnt++;
            if ({result, result_hi, flag_carry, flag_zero, illegal} !== {tbl[i].res, tbl[i].hi, tbl[i].c, tbl[i].z, tbl[i].ill})
                $display("FAIL arith[%0d] op=%h: got res=%h hi=%h c=%b z=%b ill=%b, want res=%h hi=%h c=%b z=%b ill=%b",
                         i, tbl[i].op, result, result_hi, flag_carry, flag_zero, illegal,
                         tbl[i].res, tbl[i].hi, tbl[i].c, tbl[i].z, tbl[i].ill);
            else pass_cnt++;
            total_cnt++;
            if (l !== int'(tbl[i].lat))
                $display("FAIL arith_latency[%0d]: got %0d, want %0d", i, l, tbl[i].lat);
            else pass_cnt++;
            release_result();
        end
    endtask

    task automatic test_shift();
        vec_t tbl [7];
        int   l;
        tbl = '{
            '{OP_SLL, 8'h81, 8'h03, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 5'd4},
            '{OP_SRL, 8'h81, 8'h01, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 5'd2},
            '{OP_SLL, 8'h81, 8'h00, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1},
            '{OP_SRL, 8'h81, 8'h07, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 5'd8},
            '{OP_SLL, 8'h81, 8'h0B, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 5'd4},
            '{OP_SLL, 8'h01, 8'h07, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 5'd8},
            '{OP_SRL, 8'h01, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 5'd2}
        };
        for (int i = 0; i < 7; i++) begin
            start_op(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_result(l);
            total_cnt++;
            if ({result, result_hi, flag_carry, flag_zero, illegal} !== {tbl[i].res, tbl[i].hi, tbl[i].c, tbl[i].z, tbl[i].ill})
                $display("FAIL shift[%0d] op=%h: got res=%h hi=%h c=%b z=%b ill=%b, want res=%h hi=%h c=%b z=%b ill=%b",
                         i, tbl[i].op, result, result_hi, flag_carry, flag_zero, illegal,
                         tbl[i].res, tbl[i].hi, tbl[i].c, tbl[i].z, tbl[i].ill);
            else pass_cnt++;
            total_cnt++;
            if (l !== int'(tbl[i].lat))
                $display("FAIL shift_latency[%0d]: got %0d, want %0d", i, l, tbl[i].lat);
            else pass_cnt++;
            release_result();
        end
    endtask

    task automatic test_mul_illegal();
        vec_t tbl [7];
        int   l;
        tbl = '{
`ifdef ALU_MUL_EN
            '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 5'd9},
            '{OP_MUL, 8'h00, 8'h55, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 5'd9},
            '{OP_MUL, 8'h0D, 8'h0B, 8'h8F, 8'h00, 1'b0, 1'b0, 1'b0, 5'd9},
            '{OP_MUL, 8'h10, 8'h10, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 5'd9},
`else
            '{OP_MUL, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1},
            '{OP_MUL, 8'h00, 8'h55, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1},
            '{OP_MUL, 8'h0D, 8'h0B, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1},
            '{OP_MUL, 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1},
`endif
            '{4'hF,   8'hF0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1},
            '{4'h0,   8'hF0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1},
            '{4'hA,   8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1}
        };
        for (int i = 0; i < 7; i++) begin
            start_op(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_result(l);
            total_cnt++;
            if ({result, result_hi, flag_carry, flag_zero, illegal} !== {tbl[i].res, tbl[i].hi, tbl[i].c, tbl[i].z, tbl[i].ill})
                $display("FAIL mul_illegal[%0d] op=%h: got res=%h hi=%h c=%b z=%b ill=%b, want res=%h hi=%h c=%b z=%b ill=%b",
                         i, tbl[i].op, result, result_hi, flag_carry, flag_zero, illegal,
                         tbl[i].res, tbl[i].hi, tbl[i].c, tbl[i].z, tbl[i].ill);
            else pass_cnt++;
            total_cnt++;
            if (l !== int'(tbl[i].lat))
                $display("FAIL mul_illegal_latency[%0d]: got %0d, want %0d", i, l, tbl[i].lat);
            else pass_cnt++;
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int l;
        start_op(OP_ADD, 8'h01, 8'h02);
        wait_result(l);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            in_valid  = 1'b1;
            opcode    = OP_SUB;
            operand_a = 8'h55;
            operand_b = 8'h11;
            @(posedge clock);
            #1;
            total_cnt++;
            if ({out_valid, in_ready, result, result_hi, flag_carry, flag_zero, illegal} !== {1'b1, 1'b0, 8'h03, 8'h00, 3'b000})
                $display("FAIL backpressure_hold[%0d]: got v=%b rdy=%b res=%h hi=%h c=%b z=%b ill=%b, want v=1 rdy=0 res=03 hi=00 c=0 z=0 ill=0",
                         i, out_valid, in_ready, result, result_hi, flag_carry, flag_zero, illegal);
            else pass_cnt++;
        end
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL backpressure_release: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
        else pass_cnt++;
        @(posedge clock);
        #1;
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL backpressure_no_accept: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_exec();
        int l;
`ifdef ALU_MUL_EN
        start_op(OP_MUL, 8'hFF, 8'hFF);
`else
        start_op(OP_SLL, 8'h81, 8'h07);
`endif
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL reset_mid_exec: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
        else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
        repeat (10) begin
            @(posedge clock);
            #1;
        end
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL reset_mid_exec_discard: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
        else pass_cnt++;
        start_op(OP_ADD, 8'h01, 8'h01);
        wait_result(l);
        total_cnt++;
        if ({result, result_hi, flag_carry, flag_zero, illegal} !== {8'h02, 8'h00, 3'b000})
            $display("FAIL reset_mid_exec_next: got res=%h hi=%h c=%b z=%b ill=%b, want res=02 hi=00 c=0 z=0 ill=0",
                     result, result_hi, flag_carry, flag_zero, illegal);
        else pass_cnt++;
        total_cnt++;
        if (l !== 1)
            $display("FAIL reset_mid_exec_next_latency: got %0d, want 1", l);
        else pass_cnt++;
        release_result();
    endtask

    initial begin
        test_reset();
        test_arith_logic();
        test_shift();
        test_mul_illegal();
        test_backpressure();
        test_reset_mid_exec();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Parametrised successor to the single-cycle opcode-to-ALU-control decoder. Decodes the 4-bit jacaranda-8 ALU opcode and executes the operation in one block: single-cycle logic and arithmetic, plus iterative multi-bit shifts and an optional iterative multiply.
Sits between decode and writeback. Uses valid/ready handshakes on both sides so the core stalls on multi-cycle ops.

Parameters:
WIDTH, 8, operand/result width; power of two, >= 4
SHAMT_W, $clog2(WIDTH), shift-amount bits taken from operand_b[SHAMT_W-1:0]

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
opcode  in  4  operation select
operand_a  in  WIDTH  first operand
operand_b  in  WIDTH  second operand / shift amount
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  result (product low half for MUL)
result_hi  out  WIDTH  MUL product high half; 0 for all other ops
flag_zero  out  1  result is zero (full 2*WIDTH product for MUL)
flag_carry  out  1  carry/borrow/last bit shifted out
illegal  out  1  undefined opcode; valid only with out_valid

Behaviour:
- Reset (async, active-high): state=IDLE; out_valid, result, result_hi, flags, illegal all 0; in_ready=1. Any in-flight operation is discarded. Inputs are ignored while reset is high.
- States:
  - IDLE: in_ready=1. Accept when in_valid && in_ready; latch opcode and operands.
  - EXEC: iterating.
  - DONE: out_valid=1; all outputs held stable until out_valid && out_ready, then go to IDLE.
- in_ready=0 in EXEC and DONE. There is no overlap of requests.
- Opcode table:
  - 0001 ADD: a+b; carry = carry-out.
  - 0010 SUB: a-b; carry = borrow (a<b unsigned).
  - 0011 AND.
  - 0100 OR.
  - 0101 XOR.
  - 0110 NOT a.
  - 0111 SLL: a shifted left by shamt.
  - 1000 SRL: a shifted right by shamt, logical.
  - 1001 MUL: unsigned, see Optional Feature.
  - All others: illegal=1, result=0, flags 0.
  - Logic ops have carry=0.
- Single-cycle ops and illegal opcodes go IDLE->DONE. out_valid is high on the cycle after the accept edge (latency 1).
- SLL/SRL shift one bit per EXEC cycle for shamt cycles (shamt = 0..WIDTH-1).
  - shamt=0 goes directly to DONE; result=a, carry=0.
  - Otherwise carry = last bit shifted out. Latency = shamt+1.
- MUL is shift-add: WIDTH EXEC cycles, latency WIDTH+1. Output is {result_hi,result} = a*b.
- flag_zero is computed on the final result. result_hi=0 for non-MUL ops.
- Reset mid-EXEC or mid-DONE: immediate return to IDLE with no result. The next request executes normally.

Optional Feature:
ALU_MUL_EN:
- Defined: opcode 1001 performs the iterative multiply as above.
- Undefined: multiplier logic is removed. 1001 is treated as illegal (illegal=1, result=0, result_hi=0, latency 1).

Test Plan:
- ADD a=8'hF0, b=8'h20 -> result 8'h10, carry 1, zero 0; out_valid 1 cycle after accept.
- SUB 8'h05-8'h05 -> result 0, zero 1, carry 0; SUB 8'h03-8'h05 -> 8'hFE, carry 1.
- SLL a=8'h81, b=3 -> result 8'h08, carry 0, latency 4. SRL a=8'h81, b=1 -> 8'h40, carry 1, latency 2. SLL b=0 -> 8'h81, latency 1.
- MUL 8'hFF*8'hFF with ALU_MUL_EN -> result_hi 8'hFE, result 8'h01, zero 0, latency 9. Without the macro -> illegal 1, result 0, latency 1. Opcode 4'hF -> illegal 1 in both builds.
- Backpressure: hold out_ready=0 for 5 cycles after DONE -> outputs stable, in_ready 0, a concurrent in_valid is not accepted; release -> IDLE next cycle.
- Assert reset on the 4th EXEC cycle of MUL -> out_valid 0, in_ready 1. A following ADD 1+1 -> result 2 with latency 1.
